mc_contr: RTL and testbench



---
 rtl/cpu_pkg.sv | 52 +++++
 rtl/mc_contr_if.sv | 36 +++
 rtl/mc_contr_alu_dec.sv | 24 ++
 rtl/mc_contr.sv | 188 ++++++++++++++++++
 tb/tb_mc_contr.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the MIPS control path: opcodes, funct codes, ALU
// operations, datapath select values and the multicycle state set.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;

    localparam logic [1:0] ARGB_RT     = 2'd0;
    localparam logic [1:0] ARGB_FOUR   = 2'd1;
    localparam logic [1:0] ARGB_IMM    = 2'd2;
    localparam logic [1:0] ARGB_IMM_SH = 2'd3;

    localparam logic [1:0] PCN_ALU    = 2'd0;
    localparam logic [1:0] PCN_ALUOUT = 2'd1;
    localparam logic [1:0] PCN_JUMP   = 2'd2;

    localparam logic [1:0] DST_RT  = 2'd0;
    localparam logic [1:0] DST_RD  = 2'd1;
    localparam logic [1:0] DST_R31 = 2'd2;

    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_MDR    = 2'd1;
    localparam logic [1:0] RES_PC     = 2'd2;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_ALUWB, S_ADDIEX, S_BRANCH, S_JUMP, S_ERR
    } state_t;

    // States that hold a memory request open and count wait cycles.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_contr_if.sv
// Controller-to-datapath/memory bundle: decode fields and memory ack in,
// mux selects, write strobes and memory request out.
interface mc_contr_if;

    logic [5:0] op_c;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ack;
    logic       mem_req;
    logic       mem_we;
    logic       iord_c;
    logic       ir_we;
    logic       mdr_we;
    logic       pc_we;
    logic [1:0] pc_next_c;
    logic       argA_c;
    logic [1:0] argB_c;
    logic       ext_c;
    logic [3:0] alu_c;
    logic       we_c;
    logic [1:0] dest_reg_c;
    logic [1:0] result_c;

    modport master (
        input  op_c, funct, zero, mem_ack,
        output mem_req, mem_we, iord_c, ir_we, mdr_we, pc_we, pc_next_c,
               argA_c, argB_c, ext_c, alu_c, we_c, dest_reg_c, result_c
    );

    modport slave (
        output op_c, funct, zero, mem_ack,
        input  mem_req, mem_we, iord_c, ir_we, mdr_we, pc_we, pc_next_c,
               argA_c, argB_c, ext_c, alu_c, we_c, dest_reg_c, result_c
    );

endinterface

// File: rtl/mc_contr_alu_dec.sv
// R-type funct to ALU operation decoder, shared with the single-cycle control.
module alu_dec
    import cpu_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_c,
    output logic       illegal
);

    // Map each supported funct to its ALU code; anything else is illegal.
    always_comb begin
        alu_c   = ALU_ADD;
        illegal = 1'b0;
        case (funct)
            FN_ADD:  alu_c = ALU_ADD;
            FN_SUB:  alu_c = ALU_SUB;
            FN_AND:  alu_c = ALU_AND;
            FN_OR:   alu_c = ALU_OR;
            FN_SLT:  alu_c = ALU_SLT;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_contr.sv
// Multicycle MIPS control FSM: one datapath sub-step per clock, with a
// req/ack memory handshake guarded by a wait-state timeout.
module mc_contr
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic      clk,
    input  logic      reset,
    mc_contr_if.master bus,
    output logic      busy,
    output logic      err
);

    localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT_CYC);
    localparam logic             TMO_EN = (TIMEOUT_CYC != 0);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             addi_r;
    logic [3:0]       fn_alu_s;
    logic             fn_illegal_s;
    logic             mem_state_s;
    logic             timeout_s;

    alu_dec u_alu_dec (
        .funct   (bus.funct),
        .alu_c   (fn_alu_s),
        .illegal (fn_illegal_s)
    );

    assign mem_state_s = is_mem_state(state_r);
    assign timeout_s   = TMO_EN && mem_state_s && !bus.mem_ack && (cnt_r == TMO);

    // State sequencing, wait counter and the addi write-back flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_FETCH;
            cnt_r   <= '0;
            addi_r  <= 1'b0;
        end else begin
            // Every mem state is entered from a non-waiting cycle, so clearing
            // on anything but a stalled request covers "clear on entry".
            if (mem_state_s && !bus.mem_ack) begin
                if (cnt_r != {CNT_W{1'b1}}) begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end else begin
                cnt_r <= '0;
            end

            case (state_r)
                S_FETCH: begin
                    if (bus.mem_ack)    state_r <= S_DECODE;
                    else if (timeout_s) state_r <= S_ERR;
                end
                S_DECODE: begin
                    case (bus.op_c)
                        OP_LW, OP_SW: state_r <= S_MEMADR;
                        OP_RTYPE: begin
                            state_r <= S_EXEC;
                            addi_r  <= 1'b0;
                        end
                        OP_ADDI: begin
                            state_r <= S_ADDIEX;
                            addi_r  <= 1'b1;
                        end
                        OP_BEQ:       state_r <= S_BRANCH;
                        OP_J, OP_JAL: state_r <= S_JUMP;
                        default:      state_r <= S_ERR;
                    endcase
                end
                S_MEMADR: state_r <= (bus.op_c == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD: begin
                    if (bus.mem_ack)    state_r <= S_MEMWB;
                    else if (timeout_s) state_r <= S_ERR;
                end
                S_MEMWB: state_r <= S_FETCH;
                S_MEMWR: begin
                    if (bus.mem_ack)    state_r <= S_FETCH;
                    else if (timeout_s) state_r <= S_ERR;
                end
                S_EXEC:   state_r <= fn_illegal_s ? S_ERR : S_ALUWB;
                S_ALUWB:  state_r <= S_FETCH;
                S_ADDIEX: state_r <= S_ALUWB;
                S_BRANCH: state_r <= S_FETCH;
                S_JUMP:   state_r <= S_FETCH;
                S_ERR:    state_r <= S_ERR;
                default:  state_r <= S_ERR;
            endcase
        end
    end

    // Moore decode of the current state; the ack-qualified strobes are the
    // only paths from mem_ack, and reset forces everything low immediately.
    always_comb begin
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.iord_c     = 1'b0;
        bus.ir_we      = 1'b0;
        bus.mdr_we     = 1'b0;
        bus.pc_we      = 1'b0;
        bus.pc_next_c  = PCN_ALU;
        bus.argA_c     = 1'b0;
        bus.argB_c     = ARGB_RT;
        bus.ext_c      = 1'b0;
        bus.alu_c      = ALU_AND;
        bus.we_c       = 1'b0;
        bus.dest_reg_c = DST_RT;
        bus.result_c   = RES_ALUOUT;
        busy           = 1'b0;
        err            = 1'b0;
        if (!reset) begin
            busy = 1'b1;
            case (state_r)
                S_FETCH: begin
                    bus.mem_req = 1'b1;
                    bus.argB_c  = ARGB_FOUR;
                    bus.alu_c   = ALU_ADD;
                    bus.ir_we   = bus.mem_ack;
                    bus.pc_we   = bus.mem_ack;
                end
                S_DECODE: begin
                    bus.argB_c = ARGB_IMM_SH;
                    bus.ext_c  = 1'b1;
                    bus.alu_c  = ALU_ADD;
                end
                S_MEMADR, S_ADDIEX: begin
                    bus.argA_c = 1'b1;
                    bus.argB_c = ARGB_IMM;
                    bus.ext_c  = 1'b1;
                    bus.alu_c  = ALU_ADD;
                end
                S_MEMRD: begin
                    bus.mem_req = 1'b1;
                    bus.iord_c  = 1'b1;
                    bus.mdr_we  = bus.mem_ack;
                end
                S_MEMWB: begin
                    bus.we_c     = 1'b1;
                    bus.result_c = RES_MDR;
                end
                S_MEMWR: begin
                    bus.mem_req = 1'b1;
                    bus.mem_we  = 1'b1;
                    bus.iord_c  = 1'b1;
                end
                S_EXEC: begin
                    bus.argA_c = 1'b1;
                    bus.alu_c  = fn_alu_s;
                end
                S_ALUWB: begin
                    bus.we_c       = 1'b1;
                    bus.dest_reg_c = addi_r ? DST_RT : DST_RD;
                end
                S_BRANCH: begin
                    bus.argA_c    = 1'b1;
                    bus.alu_c     = ALU_SUB;
                    bus.pc_we     = bus.zero;
                    bus.pc_next_c = PCN_ALUOUT;
                end
                S_JUMP: begin
                    bus.pc_we     = 1'b1;
                    bus.pc_next_c = PCN_JUMP;
                    if (bus.op_c == OP_JAL) begin
                        bus.we_c       = 1'b1;
                        bus.dest_reg_c = DST_R31;
                        bus.result_c   = RES_PC;
                    end else begin
                        bus.we_c = 1'b0;
                    end
                end
                S_ERR: begin
                    busy = 1'b0;
                    err  = 1'b1;
                end
                default: begin
                    busy = 1'b0;
                    err  = 1'b1;
                end
            endcase
        end else begin
            busy = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_contr.sv
// Directed bench for mc_contr: per-cycle vector table for instruction flows,
// plus hand sequences for reset, illegal funct and memory timeout.
module tb_mc_contr;

    localparam logic L = 1'b0;
    localparam logic H = 1'b1;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] T_JAL  = 6'b000011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BAD  = 6'b111111;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_NONE = 6'b000000;

    // {mem_req, mem_we, iord, ir_we, mdr_we, pc_we, pc_next[2], argA, argB[2],
    //  ext, alu[4], we, dest[2], result[2], busy, err}
    function automatic logic [22:0] ex(input logic mreq, mwe, iord, ir, mdr, pcw,
                                       input logic [1:0] pcn, input logic a,
                                       input logic [1:0] b, input logic ext,
                                       input logic [3:0] alu, input logic we,
                                       input logic [1:0] dst, res, input logic bsy, er);
        return {mreq, mwe, iord, ir, mdr, pcw, pcn, a, b, ext, alu, we, dst, res, bsy, er};
    endfunction

    function automatic logic [22:0] exe(input logic [3:0] alu);
        return ex(L, L, L, L, L, L, 2'd0, H, 2'd0, L, alu, L, 2'd0, 2'd0, H, L);
    endfunction

    localparam logic [22:0] M_STR = 23'h6E0043;
    localparam logic [22:0] M_IO  = 23'h100000;
    localparam logic [22:0] M_PCN = 23'h018000;
    localparam logic [22:0] M_A   = 23'h004000;
    localparam logic [22:0] M_B   = 23'h003000;
    localparam logic [22:0] M_EXT = 23'h000800;
    localparam logic [22:0] M_ALU = 23'h000780;
    localparam logic [22:0] M_DR  = 23'h00003C;
    localparam logic [22:0] M_ALL = 23'h7FFFFF;
    localparam logic [22:0] M_F   = M_STR | M_IO | M_PCN | M_A | M_B | M_ALU;
    localparam logic [22:0] M_DEC = M_STR | M_A | M_B | M_EXT | M_ALU;
    localparam logic [22:0] M_MEM = M_STR | M_IO;
    localparam logic [22:0] M_WB  = M_STR | M_DR;
    localparam logic [22:0] M_EX  = M_STR | M_A | M_B | M_ALU;
    localparam logic [22:0] M_BR  = M_EX | M_PCN;
    localparam logic [22:0] M_J   = M_STR | M_PCN;
    localparam logic [22:0] M_JW  = M_J | M_DR;

    localparam logic [22:0] E_F0   = ex(H, L, L, L, L, L, 2'd0, L, 2'd1, L, 4'd2, L, 2'd0, 2'd0, H, L);
    localparam logic [22:0] E_F1   = ex(H, L, L, H, L, H, 2'd0, L, 2'd1, L, 4'd2, L, 2'd0, 2'd0, H, L);
    localparam logic [22:0] E_DEC  = ex(L, L, L, L, L, L, 2'd0, L, 2'd3, H, 4'd2, L, 2'd0, 2'd0, H, L);
    localparam logic [22:0] E_MADR = ex(L, L, L, L, L, L, 2'd0, H, 2'd2, H, 4'd2, L, 2'd0, 2'd0, H, L);
    localparam logic [22:0] E_MRD0 = ex(H, L, H, L, L, L, 2'd0, L, 2'd0, L, 4'd0, L, 2'd0, 2'd0, H, L);
    localparam logic [22:0] E_MRD1 = ex(H, L, H, L, H, L, 2'd0, L, 2'd0, L, 4'd0, L, 2'd0, 2'd0, H, L);
    localparam logic [22:0] E_MWB  = ex(L, L, L, L, L, L, 2'd0, L, 2'd0, L, 4'd0, H, 2'd0, 2'd1, H, L);
    localparam logic [22:0] E_MWR  = ex(H, H, H, L, L, L, 2'd0, L, 2'd0, L, 4'd0, L, 2'd0, 2'd0, H, L);
    localparam logic [22:0] E_AWB  = ex(L, L, L, L, L, L, 2'd0, L, 2'd0, L, 4'd0, H, 2'd1, 2'd0, H, L);
    localparam logic [22:0] E_IWB  = ex(L, L, L, L, L, L, 2'd0, L, 2'd0, L, 4'd0, H, 2'd0, 2'd0, H, L);
    localparam logic [22:0] E_BRT  = ex(L, L, L, L, L, H, 2'd1, H, 2'd0, L, 4'd6, L, 2'd0, 2'd0, H, L);
    localparam logic [22:0] E_BRN  = ex(L, L, L, L, L, L, 2'd1, H, 2'd0, L, 4'd6, L, 2'd0, 2'd0, H, L);
    localparam logic [22:0] E_J    = ex(L, L, L, L, L, H, 2'd2, L, 2'd0, L, 4'd0, L, 2'd0, 2'd0, H, L);
    localparam logic [22:0] E_JAL  = ex(L, L, L, L, L, H, 2'd2, L, 2'd0, L, 4'd0, H, 2'd2, 2'd2, H, L);
    localparam logic [22:0] E_ERR  = ex(L, L, L, L, L, L, 2'd0, L, 2'd0, L, 4'd0, L, 2'd0, 2'd0, L, H);
    localparam logic [22:0] E_RST  = 23'h000000;

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        a;
        logic [22:0] exp;
        logic [22:0] msk;
    } vec_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        busy, err, busy0, err0;
    logic [22:0] act, act0;
    int          checks = 0;
    int          errors = 0;
    vec_t        tbl[$];
    string       tags[$];

    always #5 clk = ~clk;

    mc_contr_if bus ();
    mc_contr_if bus0 ();

    mc_contr #(.TIMEOUT_CYC(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .bus(bus), .busy(busy), .err(err)
    );
    mc_contr #(.TIMEOUT_CYC(0), .CNT_W(8)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .busy(busy0), .err(err0)
    );

    assign act  = {bus.mem_req, bus.mem_we, bus.iord_c, bus.ir_we, bus.mdr_we, bus.pc_we,
                   bus.pc_next_c, bus.argA_c, bus.argB_c, bus.ext_c, bus.alu_c, bus.we_c,
                   bus.dest_reg_c, bus.result_c, busy, err};
    assign act0 = {bus0.mem_req, bus0.mem_we, bus0.iord_c, bus0.ir_we, bus0.mdr_we, bus0.pc_we,
                   bus0.pc_next_c, bus0.argA_c, bus0.argB_c, bus0.ext_c, bus0.alu_c, bus0.we_c,
                   bus0.dest_reg_c, bus0.result_c, busy0, err0};

    task automatic chk(input logic [22:0] a, e, m, input string t);
        checks++;
        if ((a & m) !== (e & m)) begin
            errors++;
            $display("FAIL %s: outputs %06h, expected %06h (mask %06h)", t, a & m, e & m, m);
        end
    endtask

    task automatic step(input logic r, input logic [5:0] op, fn, input logic z, a,
                        input logic [22:0] e, m, input string t);
        @(negedge clk);
        reset       = r;
        bus.op_c    = op;
        bus.funct   = fn;
        bus.zero    = z;
        bus.mem_ack = a;
        #1;
        chk(act, e, m, t);
    endtask

    task automatic push(input logic [5:0] op, fn, input logic z, a,
                        input logic [22:0] e, m, input string t);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.a = a; v.exp = e; v.msk = m;
        tbl.push_back(v);
        tags.push_back(t);
    endtask

    // Fetch with immediate ack, then the decode cycle.
    task automatic fd(input logic [5:0] op, fn, input logic z, ak, input string t);
        push(op, fn, z, H, E_F1, M_F, t);
        push(op, fn, z, ak, E_DEC, M_DEC, t);
    endtask

    initial begin
        bus0.op_c = 6'd0; bus0.funct = 6'd0; bus0.zero = 1'b0; bus0.mem_ack = 1'b0;

        // ack tied high: add, lw, sw, beq taken, j
        fd(T_R, F_ADD, L, H, "add");  push(T_R, F_ADD, L, H, exe(4'd2), M_EX, "add");
        push(T_R, F_ADD, L, H, E_AWB, M_WB, "add");
        fd(T_LW, F_NONE, L, H, "lw"); push(T_LW, F_NONE, L, H, E_MADR, M_DEC, "lw");
        push(T_LW, F_NONE, L, H, E_MRD1, M_MEM, "lw"); push(T_LW, F_NONE, L, H, E_MWB, M_WB, "lw");
        fd(T_SW, F_NONE, L, H, "sw"); push(T_SW, F_NONE, L, H, E_MADR, M_DEC, "sw");
        push(T_SW, F_NONE, L, H, E_MWR, M_MEM, "sw");
        fd(T_BEQ, F_NONE, H, H, "beqT"); push(T_BEQ, F_NONE, H, H, E_BRT, M_BR, "beqT");
        fd(T_J, F_NONE, L, H, "j");   push(T_J, F_NONE, L, H, E_J, M_J, "j");
        // remaining ALU ops and control flow
        fd(T_ADDI, F_NONE, L, L, "addi"); push(T_ADDI, F_NONE, L, L, E_MADR, M_DEC, "addi");
        push(T_ADDI, F_NONE, L, L, E_IWB, M_WB, "addi");
        fd(T_R, F_SUB, L, L, "sub");  push(T_R, F_SUB, L, L, exe(4'd6), M_EX, "sub");
        push(T_R, F_SUB, L, L, E_AWB, M_WB, "sub");
        fd(T_R, F_AND, L, L, "and");  push(T_R, F_AND, L, L, exe(4'd0), M_EX, "and");
        push(T_R, F_AND, L, L, E_AWB, M_WB, "and");
        fd(T_R, F_OR, L, L, "or");    push(T_R, F_OR, L, L, exe(4'd1), M_EX, "or");
        push(T_R, F_OR, L, L, E_AWB, M_WB, "or");
        fd(T_R, F_SLT, L, L, "slt");  push(T_R, F_SLT, L, L, exe(4'd7), M_EX, "slt");
        push(T_R, F_SLT, L, L, E_AWB, M_WB, "slt");
        fd(T_BEQ, F_NONE, L, L, "beqN"); push(T_BEQ, F_NONE, L, L, E_BRN, M_BR, "beqN");
        fd(T_JAL, F_NONE, L, L, "jal"); push(T_JAL, F_NONE, L, L, E_JAL, M_JW, "jal");
        // fetch acked after 3 wait cycles
        for (int i = 0; i < 3; i++) push(T_J, F_NONE, L, L, E_F0, M_F, "fwait");
        fd(T_J, F_NONE, L, L, "fwait"); push(T_J, F_NONE, L, L, E_J, M_J, "fwait");
        // lw with 2 wait cycles on the data read
        fd(T_LW, F_NONE, L, L, "lwwait"); push(T_LW, F_NONE, L, L, E_MADR, M_DEC, "lwwait");
        push(T_LW, F_NONE, L, L, E_MRD0, M_MEM, "lwwait"); push(T_LW, F_NONE, L, L, E_MRD0, M_MEM, "lwwait");
        push(T_LW, F_NONE, L, H, E_MRD1, M_MEM, "lwwait"); push(T_LW, F_NONE, L, L, E_MWB, M_WB, "lwwait");
        // illegal opcode, ERR ignores ack
        fd(T_BAD, F_NONE, L, L, "badop");
        for (int i = 0; i < 3; i++) push(T_BAD, F_NONE, H, H, E_ERR, M_STR, "badop-err");

        step(H, T_R, F_NONE, L, L, E_RST, M_ALL, "reset");
        step(H, T_R, F_NONE, L, L, E_RST, M_ALL, "reset");
        for (int i = 0; i < tbl.size(); i++)
            step(L, tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].a, tbl[i].exp, tbl[i].msk,
                 $sformatf("%s[%0d]", tags[i], i));

        // Reset out of ERR, then reset in the middle of a stalled store.
        step(H, T_SW, F_NONE, L, H, E_RST, M_ALL, "rst-err");
        step(L, T_SW, F_NONE, L, H, E_F1, M_F, "sw2-fetch");
        step(L, T_SW, F_NONE, L, L, E_DEC, M_DEC, "sw2-dec");
        step(L, T_SW, F_NONE, L, L, E_MADR, M_DEC, "sw2-madr");
        step(L, T_SW, F_NONE, L, L, E_MWR, M_MEM, "sw2-wait");
        step(L, T_SW, F_NONE, L, L, E_MWR, M_MEM, "sw2-wait");
        step(H, T_SW, F_NONE, L, H, E_RST, M_ALL, "rst-midwr");
        step(L, T_R, T_BAD, L, L, E_F0, M_F, "post-rst");

        // Illegal funct reaches ERR from EXEC.
        step(L, T_R, T_BAD, L, H, E_F1, M_F, "badfn-fetch");
        step(L, T_R, T_BAD, L, L, E_DEC, M_DEC, "badfn-dec");
        step(L, T_R, T_BAD, L, L, E_AWB & 23'h000002, M_STR, "badfn-exec");
        step(L, T_R, T_BAD, L, L, E_ERR, M_STR, "badfn-err");

        // Timeout of 4: request cycles 0..4, ERR on cycle 5.
        step(H, T_R, F_NONE, L, L, E_RST, M_ALL, "rst-tmo");
        for (int i = 0; i < 5; i++) step(L, T_R, F_NONE, L, L, E_F0, M_F, $sformatf("tmo-wait%0d", i));
        step(L, T_R, F_NONE, L, L, E_ERR, M_STR, "tmo-err");

        // Timeout disabled: the second instance keeps requesting indefinitely.
        for (int i = 0; i < 300; i++) begin
            step(L, T_R, F_NONE, L, H, E_ERR, M_STR, "err-hold");
            chk(act0, E_F0, M_F, $sformatf("notmo%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
